// File: rtl/line_fifo.sv
// line_fifo: queue of vector-line records between the AVG core's line output and the rasteriser.
//
// Storage is a register array addressed by circular read/write pointers. The read side is
// show-ahead: q_* always reflect the head entry. There is no empty bypass, so a pushed entry
// appears one cycle after its push edge.
//
// Optional feature (macro LINE_FIFO_EDGE_WR_EN): when defined, only the rising edge of wr_en is
// a push attempt. A wr_en held high over several clocks therefore pushes exactly once.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_b        asynchronous active-low reset (pointers, count, overflow, storage)
//   flush        synchronous clear of pointers, count and overflow (storage kept)
//   wr_en        push request; d_* carry the line to push
//   rd_ready     consumer accepts the head entry this cycle
//   rd_valid     head entry valid (= ~empty); q_* carry the head entry
//   full / almost_full / empty / count   occupancy status, combinational from count
//   overflow     sticky: a push was dropped because the queue was full
module line_fifo #(
    parameter int unsigned COORD_W      = 13,
    parameter int unsigned INT_W        = 4,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [COORD_W-1:0]         d_start_x,
    input  logic [COORD_W-1:0]         d_end_x,
    input  logic [COORD_W-1:0]         d_start_y,
    input  logic [COORD_W-1:0]         d_end_y,
    input  logic [INT_W-1:0]           d_intensity,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [COORD_W-1:0]         q_start_x,
    output logic [COORD_W-1:0]         q_end_x,
    output logic [COORD_W-1:0]         q_start_y,
    output logic [COORD_W-1:0]         q_end_y,
    output logic [INT_W-1:0]           q_intensity,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [COORD_W-1:0] start_x;
        logic [COORD_W-1:0] end_x;
        logic [COORD_W-1:0] start_y;
        logic [COORD_W-1:0] end_y;
        logic [INT_W-1:0]   intensity;
    } line_t;

    line_t            mem_q [DEPTH];
    line_t            wdata;
    line_t            head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wr_en_eff;
    logic             push;
    logic             pop;
    logic             drop;

`ifdef LINE_FIFO_EDGE_WR_EN
    // Samples wr_en every cycle, flush included, so a request held across a flush
    // does not re-trigger afterwards.
    logic wr_en_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= wr_en;
        end
    end

    assign wr_en_eff = wr_en & ~wr_en_q;
`else
    assign wr_en_eff = wr_en;
`endif

    // Status flags are decoded straight from count, so they never lag it.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(AFULL_THRESH));
    assign empty       = (count_q == '0);
    assign rd_valid    = ~empty;
    assign count       = count_q;
    assign overflow    = overflow_q;

    // A pop frees a slot in the same cycle, so a push into a full queue is accepted
    // when it coincides with a pop.
    assign pop  = rd_valid & rd_ready;
    assign push = wr_en_eff & (~full | pop);
    assign drop = wr_en_eff & full & ~pop;

    assign wdata.start_x   = d_start_x;
    assign wdata.end_x     = d_end_x;
    assign wdata.start_y   = d_start_y;
    assign wdata.end_y     = d_end_y;
    assign wdata.intensity = d_intensity;

    assign head        = mem_q[rd_ptr_q];
    assign q_start_x   = head.start_x;
    assign q_end_x     = head.end_x;
    assign q_start_y   = head.start_y;
    assign q_end_y     = head.end_y;
    assign q_intensity = head.intensity;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Flush leaves the array untouched; only the pointers are cleared.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
